// File: rtl/core_mc.sv
`default_nettype none
// ============================================================================
// Module   : core_mc
// Purpose  : Minimal multi-cycle micro-controller. 9-bit instructions are
//            fetched from a combinational instruction memory, executed
//            against an 8 x DW register file, and loads/stores go through a
//            req/ack data-memory handshake with a bounded wait.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            start           - run request, honoured only in IDLE/HALTED
//            busy/done/error - executing / HALT retired / dmem timeout
//            imem_addr/data  - program counter out, instruction in
//            dmem_*          - data memory request/ack interface
//            cycle_count     - saturating count of busy cycles
// Revision : 1.0 - initial release
// ============================================================================
module core_mc #(
    parameter int DW      = 8,
    parameter int PCW     = 7,
    parameter int MEM_TMO = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [PCW-1:0] imem_addr,
    input  logic [8:0]     imem_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic           dmem_ack,
    output logic [31:0]    cycle_count
);

    // Wait counter only has to reach MEM_TMO-1.
    localparam int            TW       = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TMO - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_BZ  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [8:0]     ir_q, ir_d;
    logic [DW-1:0]  rf_q [8];
    logic [DW-1:0]  rf_d [8];
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [DW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [31:0]    cyc_q, cyc_d;

    // Instruction field decode from the latched IR
    logic [2:0]     opcode;
    logic [2:0]     rd;
    logic [2:0]     rs;
    logic [5:0]     imm6;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] imm_pc;

    assign opcode = ir_q[8:6];
    assign rd     = ir_q[5:3];
    assign rs     = ir_q[2:0];
    assign imm6   = ir_q[5:0];
    assign pc_inc = pc_q + PCW'(1);
    assign imm_pc = PCW'(imm6);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rf_d    = rf_q;
        done_d  = done_q;
        error_d = error_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;

        if (busy_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_HALTED: begin
                // Register file intentionally survives a restart.
                if (start) begin
                    pc_d    = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cyc_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (opcode)
                    OP_ADD: rf_d[rd] = rf_q[rd] + rf_q[rs];
                    OP_SUB: rf_d[rd] = rf_q[rd] - rf_q[rs];
                    OP_XOR: rf_d[rd] = rf_q[rd] ^ rf_q[rs];
                    OP_LDI: rf_d[0]  = DW'(imm6);
                    OP_LD, OP_ST: begin
                        // PC advances only once the access completes.
                        pc_d    = pc_q;
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        we_d    = (opcode == OP_ST);
                        addr_d  = rf_q[rs];
                        wdata_d = rf_q[rd];
                        tmo_d   = '0;
                    end
                    OP_BZ: pc_d = (rf_q[0] == '0) ? imm_pc : pc_inc;
                    default: begin
                        if (imm6 == 6'h3F) begin
                            pc_d    = pc_q;
                            done_d  = 1'b1;
                            state_d = S_HALTED;
                        end else begin
                            pc_d = imm_pc;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        rf_d[rd] = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the access: no write-back, PC left on the LD/ST.
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    error_d = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_MEM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rf_q    <= rf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign imem_addr   = pc_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign cycle_count = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mc
// Purpose  : Self-checking bench for core_mc (DW=8, PCW=6, MEM_TMO=15).
//            Directed programs cover the called-out corner cases, then random
//            forward-branching programs are compared with an instruction-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mc;

    localparam int DW      = 8;
    localparam int PCW     = 6;
    localparam int MEM_TMO = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           busy, done, error;
    logic [PCW-1:0] imem_addr;
    logic [8:0]     imem_data;
    logic           dmem_req, dmem_we;
    logic [DW-1:0]  dmem_addr, dmem_wdata;
    logic [DW-1:0]  dmem_rdata = '0;
    logic           dmem_ack = 1'b0;
    logic [31:0]    cycle_count;

    core_mc #(.DW(DW), .PCW(PCW), .MEM_TMO(MEM_TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Environment: instruction and data memories
    logic [8:0]    imem [64];
    logic [DW-1:0] dm   [256];
    assign imem_data = imem[imem_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // dmem responder plus request monitor, all at the falling edge
    int         ack_delay = 0;
    bit         spur_en = 1'b0;
    int         wcnt = 0;
    int         req_len = 0;
    int         last_req_len = 0;
    bit         unstable = 1'b0;
    logic [DW-1:0] cap_addr, cap_wdata;
    logic       cap_we;

    always @(negedge clk) begin
        if (dmem_req) begin
            if (req_len == 0) begin
                cap_addr  = dmem_addr;
                cap_wdata = dmem_wdata;
                cap_we    = dmem_we;
            end else if (cap_addr !== dmem_addr || cap_wdata !== dmem_wdata || cap_we !== dmem_we) begin
                unstable = 1'b1;
            end
            req_len++;
        end else if (req_len != 0) begin
            last_req_len = req_len;
            req_len = 0;
        end

        if (dmem_ack) begin
            dmem_ack = 1'b0;
            wcnt = 0;
        end else if (dmem_req) begin
            if (wcnt == ack_delay) begin
                dmem_ack = 1'b1;
                if (dmem_we) dm[dmem_addr] = dmem_wdata;
                else         dmem_rdata = dm[dmem_addr];
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spur_en && ($urandom_range(0, 7) == 0)) begin
                dmem_ack   = 1'b1;
                dmem_rdata = DW'($urandom);
            end
        end
    end

    function automatic logic [8:0] enc_r(input int op, input int rd, input int rs);
        return {3'(op), 3'(rd), 3'(rs)};
    endfunction

    function automatic logic [8:0] enc_i(input int op, input int imm);
        return {3'(op), 6'(imm)};
    endfunction

    localparam logic [8:0] HALT = 9'h1FF;

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = HALT;
    endtask

    // Pulse start, optionally re-pulse it at busy cycle glitch_at, wait for idle.
    task automatic run_prog(input int glitch_at);
        bit fin;
        fin = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (!busy) fin = 1'b1;
            else begin
                start = (i == glitch_at);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) chk("run_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    // Reference model: executes the program one instruction at a time
    int m_rf  [8];
    int m_mem [256];

    task automatic model_run(output int hpc);
        int pc, npc, op, rd, rs, imm;
        logic [8:0] ins;
        pc  = 0;
        hpc = -1;
        for (int step = 0; step < 500; step++) begin
            ins = imem[pc];
            op  = int'(ins[8:6]); rd = int'(ins[5:3]); rs = int'(ins[2:0]); imm = int'(ins[5:0]);
            npc = (pc + 1) % 64;
            case (op)
                0: m_rf[rd] = (m_rf[rd] + m_rf[rs]) % 256;
                1: m_rf[rd] = (m_rf[rd] - m_rf[rs] + 256) % 256;
                2: m_rf[rd] = m_rf[rd] ^ m_rf[rs];
                3: m_rf[0]  = imm;
                4: m_rf[rd] = m_mem[m_rf[rs]];
                5: m_mem[m_rf[rs]] = m_rf[rd];
                6: if (m_rf[0] == 0) npc = imm;
                default: begin
                    if (imm == 63) begin
                        hpc = pc;
                        return;
                    end
                    npc = imm;
                end
            endcase
            pc = npc;
        end
    endtask

    initial begin
        int hpc, n, op, mism;
        for (int i = 0; i < 256; i++) dm[i] = '0;
        clear_imem();
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_pc", 32'(imem_addr), 0);

        // LDI 5; ADD R1,R0; HALT
        imem[0] = enc_i(3, 5); imem[1] = enc_r(0, 1, 0); imem[2] = HALT;
        run_prog(-1);
        chk("t1_r0", 32'(dut.rf_q[0]), 5);
        chk("t1_r1", 32'(dut.rf_q[1]), 5);
        chk("t1_done", 32'(done), 1);
        chk("t1_cycles", cycle_count, 6);
        chk("t1_pc", 32'(imem_addr), 2);

        // Wrap-around arithmetic: 0-1 -> FF, FF+FF -> FE
        clear_imem();
        imem[0] = enc_r(2, 1, 1); imem[1] = enc_i(3, 1);    imem[2] = enc_r(1, 1, 0);
        imem[3] = enc_r(2, 0, 0); imem[4] = enc_r(0, 0, 1); imem[5] = enc_r(0, 0, 0);
        run_prog(-1);
        chk("t2_sub_wrap", 32'(dut.rf_q[1]), 32'hFF);
        chk("t2_add_wrap", 32'(dut.rf_q[0]), 32'hFE);
        chk("t2_cycles", cycle_count, 14);

        // ST then LD, ack three cycles late
        clear_imem();
        ack_delay = 3;
        imem[0] = enc_i(3, 40); imem[1] = enc_r(2, 3, 3); imem[2] = enc_r(0, 3, 0);
        imem[3] = enc_i(3, 23); imem[4] = enc_r(5, 0, 3); imem[5] = enc_r(4, 4, 3);
        unstable = 1'b0;
        run_prog(-1);
        chk("t3_mem", 32'(dm[40]), 23);
        chk("t3_ld", 32'(dut.rf_q[4]), 23);
        chk("t3_req_len", 32'(last_req_len), 4);
        chk("t3_stable", 32'(unstable), 0);
        chk("t3_pc", 32'(imem_addr), 6);
        chk("t3_cycles", cycle_count, 22);
        chk("t3_done", 32'(done), 1);

        // Timeout: no ack at all
        clear_imem();
        ack_delay = 1000;
        imem[0] = enc_i(3, 7); imem[1] = enc_r(4, 1, 0);
        run_prog(-1);
        chk("t4_error", 32'(error), 1);
        chk("t4_req", 32'(dmem_req), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_req_len", 32'(last_req_len), 15);
        chk("t4_no_wb", 32'(dut.rf_q[1]), 32'hFF);
        chk("t4_pc", 32'(imem_addr), 1);
        chk("t4_cycles", cycle_count, 19);

        // Branches: taken, not taken
        clear_imem();
        ack_delay = 0;
        imem[0] = enc_r(2, 0, 0); imem[1] = enc_i(6, 5); imem[2] = HALT;
        imem[5] = enc_i(3, 1);    imem[6] = enc_i(6, 9); imem[7] = HALT; imem[9] = HALT;
        run_prog(-1);
        chk("t5_error_clr", 32'(error), 0);
        chk("t5_pc", 32'(imem_addr), 7);
        chk("t5_cycles", cycle_count, 10);

        // PC wrap 63 -> 0 (R0 is 1 on entry)
        clear_imem();
        imem[0] = enc_i(6, 10); imem[1] = enc_i(7, 63 - 1 + 1 - 1 + 1); imem[63] = enc_r(2, 0, 0);
        imem[1] = enc_i(7, 0);
        imem[1][5:0] = 6'd63;
        imem[1] = 9'b111_111110;
        imem[62] = enc_r(2, 0, 0);
        imem[1] = enc_i(7, 62);
        imem[63] = enc_r(2, 0, 0);
        run_prog(-1);
        chk("t6_pc", 32'(imem_addr), 10);
        chk("t6_r0", 32'(dut.rf_q[0]), 0);
        chk("t6_cycles", cycle_count, 12);

        // Reset in the middle of a memory wait
        clear_imem();
        ack_delay = 1000;
        imem[0] = enc_i(3, 7); imem[1] = enc_r(4, 1, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
        chk("t7_in_mem", 32'(dmem_req), 1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_req", 32'(dmem_req), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_we", 32'(dmem_we), 0);
        chk("t7_cycles", cycle_count, 0);
        chk("t7_pc", 32'(imem_addr), 0);
        chk("t7_r0", 32'(dut.rf_q[0]), 0);
        reset = 1'b0;

        // start re-pulsed while busy must not restart the program
        clear_imem();
        imem[0] = enc_i(3, 5); imem[1] = enc_r(0, 1, 0); imem[2] = HALT;
        run_prog(2);
        chk("t8_cycles", cycle_count, 6);
        chk("t8_r1", 32'(dut.rf_q[1]), 5);
        chk("t8_done", 32'(done), 1);

        // Random programs against the reference model
        do_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        spur_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            clear_imem();
            n = $urandom_range(30, 6);
            for (int i = 0; i < n - 1; i++) begin
                op = $urandom_range(7, 0);
                if (op == 6 || op == 7) begin
                    if (op == 7 && $urandom_range(7, 0) == 0) imem[i] = HALT;
                    else imem[i] = enc_i(op, $urandom_range(n - 1, i + 1));
                end else if (op == 3) begin
                    imem[i] = enc_i(3, $urandom_range(63, 0));
                end else begin
                    imem[i] = enc_r(op, $urandom_range(7, 0), $urandom_range(7, 0));
                end
            end
            for (int a = 0; a < 256; a++) begin
                if (it == 0) dm[a] = DW'($urandom);
                m_mem[a] = int'(dm[a]);
            end
            ack_delay = $urandom_range(4, 0);
            model_run(hpc);
            run_prog(-1);
            for (int r = 0; r < 8; r++) chk($sformatf("rnd%0d_r%0d", it, r), 32'(dut.rf_q[r]), 32'(m_rf[r]));
            chk($sformatf("rnd%0d_pc", it), 32'(imem_addr), 32'(hpc));
            chk($sformatf("rnd%0d_done", it), 32'(done), 1);
            chk($sformatf("rnd%0d_error", it), 32'(error), 0);
            mism = 0;
            for (int a = 0; a < 256; a++) if (int'(dm[a]) != m_mem[a]) mism++;
            chk($sformatf("rnd%0d_mem", it), 32'(mism), 0);
        end
        spur_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
